// File: rtl/ava_pkg.sv
// Shared types for the AVA scan path: FSM states and the coordinate beat layout.
// Beat fields are sized for the largest supported frame; the scan controller narrows them at its ports.
package ava_pkg;

    localparam int BEAT_COORD_W = 16;
    localparam int BEAT_LIN_W   = 32;

    typedef enum logic [0:0] {
        SCAN_IDLE,
        SCAN_RUN
    } scan_state_e;

    typedef struct packed {
        logic [BEAT_COORD_W-1:0] x;
        logic [BEAT_COORD_W-1:0] y;
        logic [BEAT_LIN_W-1:0]   linear;
        logic                    active;
        logic                    hblank;
        logic                    vblank;
        logic                    line_last;
        logic                    frame_last;
    } scan_beat_t;

endpackage

// File: rtl/ava_wrap_counter.sv
// Modulo counter 0..MAX that steps on inc and flags its terminal value.
module ava_wrap_counter #(
    parameter int MAX   = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] value,
    output logic             at_max
);

    logic [WIDTH-1:0] value_q, value_d;

    assign at_max = (value_q == WIDTH'(MAX));
    assign value  = value_q;

    always_comb begin
        value_d = value_q;
        if (inc) begin
            value_d = at_max ? '0 : value_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/ava_scan_ctrl.sv
// Backpressured raster scan source: one beat per frame position (active + blanking) with
// a multiplier-free framebuffer address that supports 2^s pixel replication.
module ava_scan_ctrl
    import ava_pkg::*;
#(
    parameter int H_ACTIVE       = 640,
    parameter int V_ACTIVE       = 480,
    parameter int H_BLANK        = 160,
    parameter int V_BLANK        = 45,
    parameter int MAX_SCALE_LOG2 = 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  enable,
    input  logic [$clog2(MAX_SCALE_LOG2+1)-1:0]   scale_log2,
    input  logic                                  out_ready,
    output logic                                  out_valid,
    output logic [$clog2(H_ACTIVE+H_BLANK)-1:0]   out_x,
    output logic [$clog2(V_ACTIVE+V_BLANK)-1:0]   out_y,
    output logic [$clog2(H_ACTIVE*V_ACTIVE)-1:0]  out_linear,
    output logic                                  out_active,
    output logic                                  out_hblank,
    output logic                                  out_vblank,
    output logic                                  out_line_last,
    output logic                                  out_frame_last
);

    localparam int H_TOTAL  = H_ACTIVE + H_BLANK;
    localparam int V_TOTAL  = V_ACTIVE + V_BLANK;
    localparam int X_BITS   = $clog2(H_TOTAL);
    localparam int Y_BITS   = $clog2(V_TOTAL);
    localparam int LIN_BITS = $clog2(H_ACTIVE * V_ACTIVE);
    localparam int S_BITS   = $clog2(MAX_SCALE_LOG2 + 1);

    scan_state_e         state_q, state_d;
    logic [S_BITS-1:0]   scale_q, scale_d, scale_clamped;
    logic [LIN_BITS-1:0] line_base_q, line_base_d;
    logic [X_BITS-1:0]   x_val;
    logic [Y_BITS-1:0]   y_val;
    logic [Y_BITS:0]     y_plus1, y_mask;
    logic                x_at_max, y_at_max, frame_last, accept, run;
    scan_beat_t          beat;
    logic                unused_beat_bits;

    assign run           = (state_q == SCAN_RUN);
    assign accept        = run && out_ready;
    assign frame_last    = x_at_max && y_at_max;
    assign scale_clamped = (scale_log2 > S_BITS'(MAX_SCALE_LOG2)) ? S_BITS'(MAX_SCALE_LOG2) : scale_log2;

    // The counters hold the position of the beat on the bus, so they only move on acceptance.
    ava_wrap_counter #(.MAX(H_TOTAL - 1), .WIDTH(X_BITS)) u_x_cnt (
        .clk    (clk),
        .reset  (reset),
        .inc    (accept),
        .value  (x_val),
        .at_max (x_at_max)
    );

    ava_wrap_counter #(.MAX(V_TOTAL - 1), .WIDTH(Y_BITS)) u_y_cnt (
        .clk    (clk),
        .reset  (reset),
        .inc    (accept && x_at_max),
        .value  (y_val),
        .at_max (y_at_max)
    );

    always_comb begin
        state_d = state_q;
        scale_d = scale_q;
        case (state_q)
            SCAN_IDLE: begin
                if (enable) begin
                    state_d = SCAN_RUN;
                    scale_d = scale_clamped;
                end
            end
            SCAN_RUN: begin
                if (accept && frame_last) begin
                    if (enable) begin
                        scale_d = scale_clamped;
                    end else begin
                        state_d = SCAN_IDLE;
                    end
                end
            end
            default: state_d = SCAN_IDLE;
        endcase
    end

    // Base advances once per 2^s source lines; blank lines never reach the address.
    assign y_plus1 = {1'b0, y_val} + (Y_BITS+1)'(1);
    assign y_mask  = ~({(Y_BITS+1){1'b1}} << scale_q);

    always_comb begin
        line_base_d = line_base_q;
        if (accept) begin
            if (frame_last) begin
                line_base_d = '0;
            end else if (x_at_max && (y_val < Y_BITS'(V_ACTIVE)) && ((y_plus1 & y_mask) == '0)) begin
                line_base_d = line_base_q + (LIN_BITS'(H_ACTIVE) >> scale_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SCAN_IDLE;
            scale_q     <= '0;
            line_base_q <= '0;
        end else begin
            state_q     <= state_d;
            scale_q     <= scale_d;
            line_base_q <= line_base_d;
        end
    end

    // Payload is built purely from registers and zeroed whenever no beat is offered.
    always_comb begin
        beat = '0;
        if (run) begin
            beat.x          = BEAT_COORD_W'(x_val);
            beat.y          = BEAT_COORD_W'(y_val);
            beat.hblank     = (x_val >= X_BITS'(H_ACTIVE));
            beat.vblank     = (y_val >= Y_BITS'(V_ACTIVE));
            beat.active     = !beat.hblank && !beat.vblank;
            beat.line_last  = x_at_max;
            beat.frame_last = frame_last;
            if (beat.active) begin
                beat.linear = BEAT_LIN_W'(line_base_q + LIN_BITS'(x_val >> scale_q));
            end
        end
    end

    assign out_valid      = run;
    assign out_x          = beat.x[X_BITS-1:0];
    assign out_y          = beat.y[Y_BITS-1:0];
    assign out_linear     = beat.linear[LIN_BITS-1:0];
    assign out_active     = beat.active;
    assign out_hblank     = beat.hblank;
    assign out_vblank     = beat.vblank;
    assign out_line_last  = beat.line_last;
    assign out_frame_last = beat.frame_last;

    assign unused_beat_bits = ^{beat.x >> X_BITS, beat.y >> Y_BITS, beat.linear >> LIN_BITS};

endmodule
